// File: rtl/fft_frame_capture.sv
// fft_frame_capture: records a programmable burst of FFT output frames into
// internal memory, scans the last captured frame for its peak |re|+|im| bin,
// and offers a registered random-access readout of any stored sample.
// Optional build macro: FFT_CAPTURE_DC_SKIP_EN (exclude lane 0 from the peak search).
module fft_frame_capture #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DW     = 13,
    parameter int unsigned FRAMES = 8,
    localparam int unsigned LW    = $clog2(LANES),
    localparam int unsigned FIW   = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int unsigned CW    = $clog2(FRAMES) + 1,
    localparam int unsigned MW    = DW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  din_valid,
    input  logic [LANES*DW-1:0]   din_re,
    input  logic [LANES*DW-1:0]   din_im,
    input  logic [FIW-1:0]        rd_frame,
    input  logic [LW-1:0]         rd_lane,
    output logic [DW-1:0]         rd_re,
    output logic [DW-1:0]         rd_im,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         frame_cnt,
    output logic [LW-1:0]         peak_bin,
    output logic [MW-1:0]         peak_mag
);

    localparam int unsigned SW = LW + 1;
`ifdef FFT_CAPTURE_DC_SKIP_EN
    localparam int unsigned SCAN_START = 1;
`else
    localparam int unsigned SCAN_START = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SCAN    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [MW-1:0]     mag_q, mag_d;
    logic [LW-1:0]     mag_lane_q, mag_lane_d;
    logic [MW-1:0]     run_mag_q, run_mag_d;
    logic [LW-1:0]     run_bin_q, run_bin_d;
    logic [MW-1:0]     peak_mag_q, peak_mag_d;
    logic [LW-1:0]     peak_bin_q, peak_bin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DW-1:0]     rd_re_q, rd_re_d;
    logic [DW-1:0]     rd_im_q, rd_im_d;

    logic [LANES*DW-1:0] mem_re [FRAMES];
    logic [LANES*DW-1:0] mem_im [FRAMES];
    logic [LANES*DW-1:0] shadow_re_q;
    logic [LANES*DW-1:0] shadow_im_q;
    logic [LANES*DW-1:0] rd_word_re_c;
    logic [LANES*DW-1:0] rd_word_im_c;

    logic              wr_en_c;
    logic              shadow_ld_c;
    logic [FIW-1:0]    wr_frame_c;
    logic [LW-1:0]     scan_lane_c;
    logic [DW-1:0]     scan_re_c;
    logic [DW-1:0]     scan_im_c;
    logic [MW-1:0]     scan_mag_c;
    logic              better_c;
    logic [MW-1:0]     best_mag_c;
    logic [LW-1:0]     best_bin_c;

    // Absolute value widened by one bit so the most negative input is exact.
    function automatic logic [MW-1:0] abs_ext(input logic [DW-1:0] v);
        logic [MW-1:0] e;
        e = {v[DW-1], v};
        return v[DW-1] ? (~e + MW'(1)) : e;
    endfunction

    // Magnitude of the shadow lane under scan, and running-peak comparison of the previous lane.
    always_comb begin
        scan_lane_c = LW'(scan_cnt_q);
        scan_re_c   = shadow_re_q[32'(scan_lane_c) * DW +: DW];
        scan_im_c   = shadow_im_q[32'(scan_lane_c) * DW +: DW];
        scan_mag_c  = abs_ext(scan_re_c) + abs_ext(scan_im_c);
        better_c    = (mag_q > run_mag_q);
        best_mag_c  = better_c ? mag_q : run_mag_q;
        best_bin_c  = better_c ? mag_lane_q : run_bin_q;
        wr_frame_c  = FIW'(frame_cnt_q);
        rd_word_re_c = mem_re[rd_frame];
        rd_word_im_c = mem_im[rd_frame];
        rd_re_d     = rd_word_re_c[32'(rd_lane) * DW +: DW];
        rd_im_d     = rd_word_im_c[32'(rd_lane) * DW +: DW];
    end

    // Next-state and registered-output logic of the capture/scan controller.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        mag_d       = mag_q;
        mag_lane_d  = mag_lane_q;
        run_mag_d   = run_mag_q;
        run_bin_d   = run_bin_q;
        peak_mag_d  = peak_mag_q;
        peak_bin_d  = peak_bin_q;
        wr_en_c     = 1'b0;
        shadow_ld_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    frame_cnt_d = '0;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    frame_cnt_d = '0;
                end else if (din_valid) begin
                    wr_en_c     = 1'b1;
                    frame_cnt_d = frame_cnt_q + CW'(1);
                    if (frame_cnt_d == CW'(FRAMES)) begin
                        shadow_ld_c = 1'b1;
                        state_d     = ST_SCAN;
                        scan_cnt_d  = SW'(SCAN_START);
                        run_mag_d   = '0;
                        run_bin_d   = LW'(SCAN_START);
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_SCAN: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    frame_cnt_d = '0;
                end else begin
                    // mag_q holds the lane loaded last cycle; fold it in once valid.
                    if (scan_cnt_q != SW'(SCAN_START)) begin
                        run_mag_d = best_mag_c;
                        run_bin_d = best_bin_c;
                    end
                    if (scan_cnt_q == SW'(LANES)) begin
                        peak_mag_d = best_mag_c;
                        peak_bin_d = best_bin_c;
                        state_d    = ST_DONE;
                    end else begin
                        mag_d      = scan_mag_c;
                        mag_lane_d = scan_lane_c;
                        scan_cnt_d = scan_cnt_q + SW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    frame_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) || (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
    end

    // Controller state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            scan_cnt_q  <= '0;
            mag_q       <= '0;
            mag_lane_q  <= '0;
            run_mag_q   <= '0;
            run_bin_q   <= '0;
            peak_mag_q  <= '0;
            peak_bin_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_re_q     <= '0;
            rd_im_q     <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            mag_q       <= mag_d;
            mag_lane_q  <= mag_lane_d;
            run_mag_q   <= run_mag_d;
            run_bin_q   <= run_bin_d;
            peak_mag_q  <= peak_mag_d;
            peak_bin_q  <= peak_bin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_re_q     <= rd_re_d;
            rd_im_q     <= rd_im_d;
        end
    end

    // Frame memory and scan shadow; not reset, contents survive re-arm and reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_re[wr_frame_c] <= din_re;
            mem_im[wr_frame_c] <= din_im;
        end
        if (shadow_ld_c) begin
            shadow_re_q <= din_re;
            shadow_im_q <= din_im;
        end
    end

    assign rd_re     = rd_re_q;
    assign rd_im     = rd_im_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign peak_bin  = peak_bin_q;
    assign peak_mag  = peak_mag_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture (LANES=16, DW=13, FRAMES=4).
// Expected values follow FFT_CAPTURE_DC_SKIP_EN when it is defined.
module tb_fft_frame_capture;

    localparam int LANES  = 16;
    localparam int DW     = 13;
    localparam int FRAMES = 4;
`ifdef FFT_CAPTURE_DC_SKIP_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 17;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                arm;
    logic                din_valid;
    logic [LANES*DW-1:0] din_re;
    logic [LANES*DW-1:0] din_im;
    logic [1:0]          rd_frame;
    logic [3:0]          rd_lane;
    logic [DW-1:0]       rd_re;
    logic [DW-1:0]       rd_im;
    logic                busy;
    logic                done;
    logic [2:0]          frame_cnt;
    logic [3:0]          peak_bin;
    logic [DW:0]         peak_mag;

    int checks   = 0;
    int failures = 0;

    fft_frame_capture #(.LANES(LANES), .DW(DW), .FRAMES(FRAMES)) dut (
        .clk(clk), .rst(rst), .arm(arm), .din_valid(din_valid),
        .din_re(din_re), .din_im(din_im), .rd_frame(rd_frame), .rd_lane(rd_lane),
        .rd_re(rd_re), .rd_im(rd_im), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .peak_bin(peak_bin), .peak_mag(peak_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int base;                 // lane k gets re = k*base, im = 0
        int la; int ra; int ia;   // override lane a
        int lb; int rb; int ib;   // override lane b (-1 = none)
        int exp_bin;
        int exp_mag;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int base, input int la, input int ra, input int ia,
                              input int lb, input int rb, input int ib);
        for (int k = 0; k < LANES; k++) begin
            int re;
            int im;
            re = k * base;
            im = 0;
            if (k == la) begin re = ra; im = ia; end
            if (k == lb) begin re = rb; im = ib; end
            din_re[k*DW +: DW] = 13'(re);
            din_im[k*DW +: DW] = 13'(im);
        end
    endtask

    task automatic beat();
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    int prev_bin;
    int prev_mag;
    int done_rises;
    logic done_prev;

    initial begin
        vecs[0] = '{10, 3, 1000, 0, -1, 0, 0, 3, 1000};
        vecs[1] = '{0, 7, -4096, -4096, -1, 0, 0, 7, 8192};
        vecs[2] = '{10, 2, 500, 0, 5, 500, 0, 2, 500};
`ifdef FFT_CAPTURE_DC_SKIP_EN
        vecs[3] = '{0, 0, 3000, 0, 9, 200, 0, 9, 200};
        vecs[4] = '{0, -1, 0, 0, -1, 0, 0, 1, 0};
`else
        vecs[3] = '{0, 0, 3000, 0, 9, 200, 0, 0, 3000};
        vecs[4] = '{0, -1, 0, 0, -1, 0, 0, 0, 0};
`endif
        vecs[5] = '{10, 12, -7, -300, -1, 0, 0, 12, 307};

        rst = 1'b1; arm = 1'b0; din_valid = 1'b0;
        din_re = '0; din_im = '0; rd_frame = '0; rd_lane = '0;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_peak_bin", int'(peak_bin), 0);
        chk("rst_peak_mag", int'(peak_mag), 0);
        chk("rst_rd_re", int'(rd_re), 0);
        rst = 1'b0;
        step();

        // IDLE ignores din_valid
        load_frame(1, -1, 0, 0, -1, 0, 0);
        beat(); beat();
        chk("idle_ignore_cnt", int'(frame_cnt), 0);
        chk("idle_ignore_busy", int'(busy), 0);

        prev_bin = 0;
        prev_mag = 0;
        for (int i = 0; i < 6; i++) begin
            arm = 1'b1; step(); arm = 1'b0;
            chk($sformatf("v%0d_busy_armed", i), int'(busy), 1);
            load_frame(vecs[i].base, vecs[i].la, vecs[i].ra, vecs[i].ia,
                       vecs[i].lb, vecs[i].rb, vecs[i].ib);
            for (int f = 0; f < FRAMES; f++) begin
                beat();
                if ((i % 2 == 1) && (f < FRAMES - 1)) step();
            end
            // last beat was sampled at edge E; now just past E
            for (int n = 1; n <= LAT; n++) begin
                step();
                if (n == LAT - 1) begin
                    chk($sformatf("v%0d_done_early", i), int'(done), 0);
                    chk($sformatf("v%0d_peak_hold", i), int'(peak_bin), prev_bin);
                end
            end
            chk($sformatf("v%0d_done", i), int'(done), 1);
            chk($sformatf("v%0d_frame_cnt", i), int'(frame_cnt), FRAMES);
            chk($sformatf("v%0d_peak_bin", i), int'(peak_bin), vecs[i].exp_bin);
            chk($sformatf("v%0d_peak_mag", i), int'(peak_mag), vecs[i].exp_mag);
            prev_bin = vecs[i].exp_bin;
            prev_mag = vecs[i].exp_mag;

            if (i == 0) begin
                rd_frame = 2'd2; rd_lane = 4'd15;
                step();
                chk("rd_f2_l15_re", int'($signed(rd_re)), 150);
                rd_frame = 2'd3; rd_lane = 4'd3;
                step();
                chk("rd_f3_l3_re", int'($signed(rd_re)), 1000);
                chk("rd_f3_l3_im", int'($signed(rd_im)), 0);
            end
            if (i == 1) begin
                rd_frame = 2'd0; rd_lane = 4'd7;
                step();
                chk("rd_f0_l7_im", int'($signed(rd_im)), -4096);
            end
            if (i == 2) begin
                beat();
                chk("done_ignore_cnt", int'(frame_cnt), FRAMES);
                chk("done_ignore_done", int'(done), 1);
            end
        end

        // Reset five cycles into SCAN
        arm = 1'b1; step(); arm = 1'b0;
        load_frame(10, 3, 1000, 0, -1, 0, 0);
        for (int f = 0; f < FRAMES; f++) beat();
        repeat (5) step();
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_peak_mag", int'(peak_mag), 0);
        chk("mid_rst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        step();
        beat(); beat(); beat();
        repeat (LANES + 3) step();
        chk("post_rst_cnt", int'(frame_cnt), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);

        // Restart mid-capture with arm coincident with a valid beat
        arm = 1'b1; step(); arm = 1'b0;
        load_frame(0, 0, 11, 0, -1, 0, 0); beat();
        load_frame(0, 0, 22, 0, -1, 0, 0); beat();
        chk("rs_cnt_2", int'(frame_cnt), 2);
        load_frame(0, 0, 33, 0, -1, 0, 0);
        arm = 1'b1; din_valid = 1'b1; step(); arm = 1'b0; din_valid = 1'b0;
        chk("rs_cnt_rearm", int'(frame_cnt), 0);
        rd_frame = 2'd0; rd_lane = 4'd0;
        load_frame(0, 0, 41, 0, -1, 0, 0); beat();
        chk("rs_cnt_1", int'(frame_cnt), 1);
        chk("rs_rd_old", int'($signed(rd_re)), 11);
        load_frame(0, 0, 42, 0, -1, 0, 0); beat();
        chk("rs_rd_new", int'($signed(rd_re)), 41);
        chk("rs_cnt_2b", int'(frame_cnt), 2);
        load_frame(0, 0, 43, 0, -1, 0, 0); beat();
        load_frame(0, 0, 44, 0, -1, 0, 0); beat();
        chk("rs_cnt_4", int'(frame_cnt), 4);
        done_rises = 0;
        done_prev = done;
        for (int n = 1; n <= LAT + 6; n++) begin
            step();
            if (done && !done_prev) done_rises++;
            done_prev = done;
        end
        chk("rs_done_once", done_rises, 1);
        rd_frame = 2'd1; rd_lane = 4'd0;
        step();
        chk("rs_rd_f1", int'($signed(rd_re)), 42);
`ifdef FFT_CAPTURE_DC_SKIP_EN
        chk("rs_peak_bin", int'(peak_bin), 1);
        chk("rs_peak_mag", int'(peak_mag), 0);
`else
        chk("rs_peak_bin", int'(peak_bin), 0);
        chk("rs_peak_mag", int'(peak_mag), 44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- Parametrised capture engine that sits between fft_top and the on-chip debug probes.
- Records a programmable burst of parallel FFT output frames into internal memory.
- Scans the last captured frame for its peak-magnitude bin.
- Exposes a random-access readout port, so every lane (including the last one) is observable without a 33-probe VIO.

Parameters:
LANES, 16, parallel FFT bins per frame (power of 2, >=2)
DW, 13, signed width of each re/im sample
FRAMES, 8, frames captured per arm (power of 2, >=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
arm  in  1  single-cycle pulse: start/restart a capture
din_valid  in  1  FFT output frame valid (fft_top output_en)
din_re  in  LANES*DW  real parts, lane k at [k*DW +: DW], signed
din_im  in  LANES*DW  imaginary parts, same packing
rd_frame  in  log2(FRAMES)  readout frame index
rd_lane  in  log2(LANES)  readout lane index
rd_re  out  DW  registered readout, real
rd_im  out  DW  registered readout, imag
busy  out  1  high in ARMED, CAPTURE, SCAN
done  out  1  high in DONE
frame_cnt  out  log2(FRAMES)+1  frames stored since last arm
peak_bin  out  log2(LANES)  lane index of peak magnitude
peak_mag  out  DW+1  unsigned |re|+|im| of peak lane

Behaviour:
- Reset: state IDLE; busy=0, done=0, frame_cnt=0, peak_bin=0, peak_mag=0, rd_re=0, rd_im=0. Frame memory is not cleared.
- States: IDLE, ARMED, CAPTURE, SCAN, DONE.
- IDLE: arm -> ARMED. din_valid is ignored.
- ARMED:
  - First din_valid beat is written to frame 0; frame_cnt becomes 1; state -> CAPTURE.
  - If FRAMES=1, state goes directly to SCAN instead.
- CAPTURE:
  - Each din_valid beat is written to frame index frame_cnt; frame_cnt increments.
  - Beats need not be contiguous.
  - On the beat that makes frame_cnt=FRAMES, the frame is also copied to a shadow register; state -> SCAN.
- SCAN:
  - One lane per cycle, index 0..LANES-1, reading the shadow register.
  - mag = |re| + |im|, computed at DW+1 bits. |-(2^(DW-1))| = 2^(DW-1), so no saturation is needed.
  - The running peak updates only on strictly greater mag, so ties resolve to the lowest index.
  - peak_bin/peak_mag update once, on the cycle SCAN exits; they hold the previous values during the scan.
  - Exits after LANES cycles -> DONE.
- Latency: if the last capture beat is sampled at edge E, done=1 from edge E+LANES+1.
- DONE: holds results. arm -> ARMED (done drops, frame_cnt=0). din_valid is ignored.
- arm in ARMED, CAPTURE or SCAN: abort and restart.
  - State -> ARMED, frame_cnt=0, scan discarded, peak outputs unchanged.
  - A din_valid beat on the same cycle as arm is not captured.
- Readout:
  - rd_re/rd_im = mem[rd_frame][rd_lane], registered with 1-cycle latency, valid in any state.
  - A read and a write to the same location in the same cycle returns old data.
  - Reading frames >= frame_cnt returns stale contents.
- Reset mid-operation: immediate return to reset values, regardless of state.

Optional Feature:
- Macro: FFT_CAPTURE_DC_SKIP_EN.
- Defined:
  - SCAN starts at lane 1 and takes LANES-1 cycles.
  - Lane 0 (DC) is excluded from the peak search; peak_bin is never 0 unless all other lanes are 0. In that case peak_bin=1, peak_mag=0.
  - done latency becomes E+LANES.
- Undefined: all lanes are scanned, as above.

Test Plan:
- Basic capture. LANES=16, DW=13, FRAMES=4; arm, then 4 valid beats, all lanes re=lane*10, im=0 except lane 3 re=1000.
  - Required: frame_cnt=4; peak_bin=3, peak_mag=1000; done at E+17.
  - Readback of frame 2 lane 15 gives rd_re=150 one cycle after the address is applied.
- Extreme values. Last frame has lane 7 re=-4096, im=-4096; all other lanes are 0.
  - Required: peak_bin=7, peak_mag=8192 (no overflow).
- Tie-break. Lanes 2 and 5 both re=500, im=-0 (im=0); all other lanes smaller.
  - Required: peak_bin=2.
- Restart mid-capture. arm, 2 valid beats, then arm coincident with a valid beat, then 4 valid beats.
  - Required: the coincident beat is dropped, frame_cnt counts 0->4, frame 0 holds the first post-rearm beat, done asserts once.
- Reset mid-scan. Pulse rst 5 cycles into SCAN.
  - Required: busy=0, done=0, peak_mag=0, frame_cnt=0 asynchronously; din_valid is ignored until the next arm.
- FFT_CAPTURE_DC_SKIP_EN defined. Lane 0 re=3000, lane 9 re=200, all other lanes 0.
  - Required: peak_bin=9, peak_mag=200, done at E+16.
  - With the macro undefined, the same stimulus gives peak_bin=0, peak_mag=3000.
